// File: rtl/hour_counter_p_if.sv
// hour_counter_p request/response bundle.
// Master drives requests, slave returns count and display views.
interface hour_counter_p_if #(
    parameter int WIDTH = 5
);
    logic             tick_in;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             adj_inc;
    logic             adj_dec;
    logic             mode12;
    logic             enable;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] databus;
    logic [WIDTH-1:0] disp;
    logic             pm;
    logic [7:0]       disp_bcd;
    logic             carry_out;
    logic             load_err;

    modport master (
        output tick_in, load, data,
        output adj_inc, adj_dec,
        output mode12, enable,
        input  count, databus, disp,
        input  pm, disp_bcd,
        input  carry_out, load_err
    );

    modport slave (
        input  tick_in, load, data,
        input  adj_inc, adj_dec,
        input  mode12, enable,
        output count, databus, disp,
        output pm, disp_bcd,
        output carry_out, load_err
    );
endinterface

// File: rtl/hour_counter_p.sv
// Parametrised time-unit counter with carry chain,
// bounded load, set-button adjust and 12h/BCD display.
module hour_counter_p #(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 24,
    parameter int HAS_12H = 1,
    parameter int BCD_OUT = 1
) (
    input  logic clk,
    input  logic clear,
    hour_counter_p_if.slave bus
);
    // 12h view only makes sense for a 24-step day
    localparam bit H12 =
        (HAS_12H != 0) && (MODULUS == 24);
    localparam bit BCD_EN =
        (BCD_OUT != 0) && (MODULUS <= 100);
    localparam logic [WIDTH-1:0] TOP =
        WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0] MODV =
        (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] NOON =
        WIDTH'(12);
    localparam logic [WIDTH-1:0] ONE =
        WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic             carry_q;
    logic             err_q;
    logic [WIDTH-1:0] inc_v;
    logic [WIDTH-1:0] dec_v;
    logic [WIDTH-1:0] disp_v;
    logic [7:0]       bcd_v;
    logic [31:0]      dv;

    // Wrapping neighbours of the current count
    always_comb begin
        inc_v = count_q + ONE;
        dec_v = count_q - ONE;
        if (count_q == TOP)
            inc_v = '0;
        if (count_q == '0)
            dec_v = TOP;
    end

    // Counter state: clear > load > adjust > tick
    always_ff @(posedge clk) begin
        if (!clear) begin
            count_q <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            if (bus.load) begin
                if ({1'b0, bus.data} < MODV)
                    count_q <= bus.data;
                else
                    err_q <= 1'b1;
            end else if (bus.adj_inc || bus.adj_dec) begin
                if (bus.adj_inc && !bus.adj_dec)
                    count_q <= inc_v;
                else if (bus.adj_dec && !bus.adj_inc)
                    count_q <= dec_v;
            end else if (bus.tick_in) begin
                count_q <= inc_v;
                carry_q <= (count_q == TOP);
            end
        end
    end

    // Display value: 12h fold maps 0 to 12 and 13..23 to 1..11
    always_comb begin
        disp_v = count_q;
        if (H12 && bus.mode12) begin
            if (count_q == '0)
                disp_v = NOON;
            else if (count_q > NOON)
                disp_v = count_q - NOON;
        end
    end

    // Two-digit BCD of the display value
    always_comb begin
        dv    = 32'(disp_v);
        bcd_v = 8'h00;
        if (BCD_EN)
            bcd_v = {4'(dv / 32'd10), 4'(dv % 32'd10)};
    end

    assign bus.count     = count_q;
    assign bus.databus   = bus.enable ? count_q : '0;
    assign bus.disp      = disp_v;
    assign bus.pm        = H12 && (count_q >= NOON);
    assign bus.disp_bcd  = bcd_v;
    assign bus.carry_out = carry_q;
    assign bus.load_err  = err_q;
endmodule

// File: tb/tb_hour_counter_p.sv
// Bench for hour_counter_p: a 24h instance and a 60-step
// instance checked each cycle against an arithmetic model.
module tb_hour_counter_p;
    logic clk = 1'b0;
    logic clear;
    int   errors = 0;
    int   checks = 0;

    int   ca, cb;
    bit   cara, carb, erra, errb;

    always #5 clk = ~clk;

    hour_counter_p_if #(.WIDTH(5)) a ();
    hour_counter_p_if #(.WIDTH(6)) b ();

    hour_counter_p #(
        .WIDTH(5), .MODULUS(24),
        .HAS_12H(1), .BCD_OUT(1)
    ) u24 (
        .clk(clk), .clear(clear), .bus(a.slave)
    );

    hour_counter_p #(
        .WIDTH(6), .MODULUS(60),
        .HAS_12H(0), .BCD_OUT(1)
    ) u60 (
        .clk(clk), .clear(clear), .bus(b.slave)
    );

    function automatic void model(
        input int m, input bit cl, input bit ld,
        input int d, input bit inc, input bit dec,
        input bit tk, inout int c,
        inout bit car, inout bit er);
        car = 1'b0;
        er  = 1'b0;
        if (!cl) begin
            c = 0;
        end else if (ld) begin
            if (d < m) c = d;
            else er = 1'b1;
        end else if (inc || dec) begin
            if (inc && !dec) c = (c + 1) % m;
            if (dec && !inc) c = (c + m - 1) % m;
        end else if (tk) begin
            if (c == m - 1) begin
                c = 0;
                car = 1'b1;
            end else begin
                c = c + 1;
            end
        end
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic check_dut(
        input string n, input int m, input bit h12,
        input int c, input bit car, input bit er,
        input bit mode, input bit en,
        input logic [31:0] cnt, input logic [31:0] db,
        input logic [31:0] ds, input logic [31:0] pmv,
        input logic [31:0] bcd, input logic [31:0] co,
        input logic [31:0] le);
        int d;
        d = c;
        if (h12 && m == 24 && mode) begin
            if (c == 0) d = 12;
            else if (c > 12) d = c - 12;
        end
        chk({n, ".count"}, cnt, c);
        chk({n, ".databus"}, db, en ? c : 0);
        chk({n, ".disp"}, ds, d);
        chk({n, ".pm"}, pmv, (h12 && m == 24 && c >= 12) ? 1 : 0);
        chk({n, ".bcd"}, bcd, (d / 10) * 16 + d % 10);
        chk({n, ".carry"}, co, car);
        chk({n, ".err"}, le, er);
    endtask

    task automatic step();
        model(24, clear, a.load, int'(a.data),
              a.adj_inc, a.adj_dec, a.tick_in,
              ca, cara, erra);
        model(60, clear, b.load, int'(b.data),
              b.adj_inc, b.adj_dec, b.tick_in,
              cb, carb, errb);
        @(posedge clk);
        #1;
        check_dut("h24", 24, 1'b1, ca, cara, erra,
                  a.mode12, a.enable,
                  32'(a.count), 32'(a.databus),
                  32'(a.disp), 32'(a.pm),
                  32'(a.disp_bcd), 32'(a.carry_out),
                  32'(a.load_err));
        check_dut("m60", 60, 1'b0, cb, carb, errb,
                  b.mode12, b.enable,
                  32'(b.count), 32'(b.databus),
                  32'(b.disp), 32'(b.pm),
                  32'(b.disp_bcd), 32'(b.carry_out),
                  32'(b.load_err));
    endtask

    task automatic idle();
        a.tick_in = 0; a.load = 0; a.data = '0;
        a.adj_inc = 0; a.adj_dec = 0;
        b.tick_in = 0; b.load = 0; b.data = '0;
        b.adj_inc = 0; b.adj_dec = 0;
    endtask

    task automatic load_a(input int v);
        idle();
        a.load = 1;
        a.data = 5'(v);
        step();
        a.load = 0;
    endtask

    task automatic load_b(input int v);
        idle();
        b.load = 1;
        b.data = 6'(v);
        step();
        b.load = 0;
    endtask

    initial begin
        ca = 0; cb = 0;
        cara = 0; carb = 0; erra = 0; errb = 0;
        idle();
        a.mode12 = 0; a.enable = 1;
        b.mode12 = 0; b.enable = 1;
        clear = 0;
        step();
        step();
        chk("rst.count", 32'(a.count), 0);
        chk("rst.bcd", 32'(a.disp_bcd), 32'h00);
        a.mode12 = 1;
        step();
        chk("rst.disp12", 32'(a.disp), 12);
        chk("rst.bcd12", 32'(a.disp_bcd), 32'h12);
        a.mode12 = 0;
        clear = 1;

        // full day of ticks
        a.tick_in = 1;
        repeat (24) step();
        chk("day.wrap", 32'(a.carry_out), 1);
        a.tick_in = 0;
        step();
        chk("day.carry1", 32'(a.carry_out), 0);

        // 12h display view
        a.mode12 = 1;
        load_a(17);
        chk("l17.disp", 32'(a.disp), 5);
        chk("l17.bcd", 32'(a.disp_bcd), 32'h05);
        chk("l17.pm", 32'(a.pm), 1);
        load_a(0);
        chk("l0.disp", 32'(a.disp), 12);
        a.mode12 = 0;
        step();
        chk("l0.raw", 32'(a.disp_bcd), 32'h00);

        // bounded load
        load_a(9);
        load_a(25);
        chk("l25.err", 32'(a.load_err), 1);
        chk("l25.hold", 32'(a.count), 9);
        step();
        load_a(23);
        chk("l23.count", 32'(a.count), 23);

        // set buttons
        load_a(0);
        a.adj_dec = 1; step(); a.adj_dec = 0;
        chk("dec.wrap", 32'(a.count), 23);
        a.adj_inc = 1; step();
        chk("inc.wrap", 32'(a.count), 0);
        a.adj_dec = 1; step();
        a.adj_inc = 0; a.adj_dec = 0;
        load_a(5);
        a.adj_inc = 1; a.tick_in = 1; step();
        chk("inc.tick", 32'(a.count), 6);
        idle();

        // clear wins over everything
        load_a(23);
        clear = 0; a.tick_in = 1; a.load = 1;
        a.data = 5'd4;
        step();
        chk("clr.count", 32'(a.count), 0);
        clear = 1;
        idle();

        // databus gating
        load_a(7);
        a.enable = 0; step();
        chk("en0", 32'(a.databus), 0);
        a.enable = 1; step();
        chk("en1", 32'(a.databus), 7);

        // 60-step instance
        load_b(59);
        b.tick_in = 1; step(); b.tick_in = 0;
        chk("b.wrap", 32'(b.carry_out), 1);
        load_b(60);
        chk("b.err", 32'(b.load_err), 1);
        load_b(45);
        chk("b.bcd", 32'(b.disp_bcd), 32'h45);

        // random traffic on both instances
        for (int i = 0; i < 600; i++) begin
            clear     = ($urandom_range(0, 39) != 0);
            a.load    = ($urandom_range(0, 7) == 0);
            a.data    = 5'($urandom);
            a.adj_inc = ($urandom_range(0, 5) == 0);
            a.adj_dec = ($urandom_range(0, 5) == 0);
            a.tick_in = ($urandom_range(0, 1) == 0);
            a.mode12  = 1'($urandom);
            a.enable  = 1'($urandom);
            b.load    = ($urandom_range(0, 7) == 0);
            b.data    = 6'($urandom);
            b.adj_inc = ($urandom_range(0, 5) == 0);
            b.adj_dec = ($urandom_range(0, 5) == 0);
            b.tick_in = ($urandom_range(0, 3) != 0);
            b.mode12  = 1'($urandom);
            b.enable  = 1'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule

// File: doc/hour_counter_p.md
Name: hour_counter_p

Overview:
Parametrised time-unit counter, the next generation of the clock's hour stage, usable for hours, minutes, seconds or calendar fields. It advances on a carry pulse from the lower unit and issues a registered carry to the next stage. It supports bounded load with error flagging, manual up/down adjust for the set buttons, and a 12-hour display view with AM/PM and a BCD output for the 7-segment drivers. A tri-state-style databus output is gated by enable.

Parameters:
WIDTH, 5, counter width in bits; MODULUS must be <= 2**WIDTH
MODULUS, 24, count range is 0..MODULUS-1
HAS_12H, 1, enables the 12-hour display path; only legal when MODULUS==24, otherwise it is treated as 0
BCD_OUT, 1, enables the disp_bcd output; only legal when MODULUS<=100, otherwise disp_bcd is held at 0

Ports:
clk  in  1  clock, all state updates on posedge
clear  in  1  synchronous reset, active-low
tick_in  in  1  one-cycle carry from lower unit (minute carry)
load  in  1  load data into count
data  in  WIDTH  load value
adj_inc  in  1  manual +1 pulse (set button)
adj_dec  in  1  manual -1 pulse (set button)
mode12  in  1  1 = 12-hour display view, 0 = raw view
enable  in  1  databus output enable
count  out  WIDTH  raw counter value (0..MODULUS-1)
databus  out  WIDTH  count when enable=1, else 0
disp  out  WIDTH  display value
pm  out  1  count>=12 when HAS_12H, else 0
disp_bcd  out  8  {tens, ones} BCD of disp
carry_out  out  1  registered wrap pulse to next stage
load_err  out  1  registered out-of-range load pulse

Behaviour:
- All state is registered on posedge clk. When clear==0 at an edge: count=0, carry_out=0, load_err=0. No other input is honoured that cycle.
- Priority per edge: clear > load > adjust (adj_inc/adj_dec) > tick_in. A lower-priority request is dropped in the same cycle, not deferred.
- load=1:
  - data<MODULUS: count<=data.
  - data>=MODULUS: count is held and load_err<=1 for exactly one cycle.
  - carry_out<=0 in both cases.
- Adjust (only when load=0):
  - adj_inc alone: count<=count+1, or 0 if count==MODULUS-1.
  - adj_dec alone: count<=count-1, or MODULUS-1 if count==0.
  - Both high: count held.
  - No carry_out is generated on adjust wrap. tick_in is ignored in any cycle where adj_inc or adj_dec is high.
- tick_in (no load, no adjust):
  - count<=count+1.
  - At count==MODULUS-1: count<=0 and carry_out<=1.
  - carry_out is high for exactly one cycle, coincident with count==0.
- tick_in=0 and no other request: count held, carry_out<=0, load_err<=0.
- Arithmetic is modulo MODULUS in WIDTH bits. No out-of-range value may ever appear on count.
- Combinational outputs, derived from registers only:
  - databus = enable ? count : 0.
  - pm = (count>=12) when HAS_12H, else 0.
  - disp when HAS_12H && mode12: count==0 -> 12; count>12 -> count-12; else count.
  - disp otherwise: count.
  - disp_bcd = {disp/10, disp%10}, 4 bits each.
- mode12 affects display outputs only. Toggling it never alters count.
- Reset outputs (count 0): databus=0, pm=0, disp=12 if mode12&&HAS_12H else 0, disp_bcd=8'h12 or 8'h00 correspondingly, carry_out=0, load_err=0.
- Latency: count/carry_out/load_err have one-cycle latency from request. Display paths have zero latency from count.

Test Plan:
- Reset (clear=0), then 24 tick_in pulses -> count 0,1,...,23,0; carry_out=1 only in the cycle count returns to 0; pm rises at count=12.
- load=1, data=17, mode12=1 -> count=17, disp=5, pm=1, disp_bcd=8'h05; then load data=0 -> disp=12, disp_bcd=8'h12, pm=0; mode12=0 -> disp=0, disp_bcd=8'h00.
- count=9, load data=25 -> count stays 9, load_err=1 for one cycle then 0; load data=23 in the same sequence -> count=23, load_err=0.
- count=0, adj_dec -> 23, carry_out=0; adj_inc -> 0, carry_out=0; adj_inc+adj_dec together -> held; adj_inc with tick_in at count=5 -> 6 (tick dropped).
- count=23, tick_in=1, load=1 and clear=0 together -> count=0, carry_out=0, load_err=0; enable=0 with count=7 -> databus=0, enable=1 -> databus=7.
- Instance WIDTH=6, MODULUS=60, HAS_12H=0 -> load 59, tick_in -> count=0, carry_out=1, disp_bcd=8'h00; load 60 -> load_err=1; load 45 -> disp_bcd=8'h45, pm=0.
